// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice resolved per stage, carry
// registered between stages, valid/ready handshake on both sides with collapsing bubbles.
module pipelined_rca #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] carry;
  logic [STAGES-1:0] adv;
  // Resolved result slices overlay the low slices of operand a as the word moves down
  logic [WIDTH-1:0]  word [STAGES];
  logic [WIDTH-1:0]  opb  [STAGES];
  logic              ovf_q;

  always_comb begin
    adv = '0;
    adv[STAGES-1] = !valid[STAGES-1] || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      adv[k] = !valid[k] || adv[k+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vin;
    logic             cin_k;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] word_d;
    logic [CHUNK:0]   slice;
    logic             valid_q;
    logic             carry_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] opb_q;

    if (k == 0) begin : g_first
      assign vin   = in_valid;
      assign ain   = a;
      assign bin   = sub ? ~b : b;
      assign cin_k = sub | cin;
    end else begin : g_next
      assign vin   = valid[k-1];
      assign ain   = word[k-1];
      assign bin   = opb[k-1];
      assign cin_k = carry[k-1];
    end

    assign slice = {1'b0, ain[k*CHUNK +: CHUNK]} + {1'b0, bin[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, cin_k};

    always_comb begin
      word_d = ain;
      word_d[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        word_q  <= '0;
        opb_q   <= '0;
      end else if (adv[k]) begin
        valid_q <= vin;
        carry_q <= slice[CHUNK];
        word_q  <= word_d;
        opb_q   <= bin;
      end
    end

    assign valid[k] = valid_q;
    assign carry[k] = carry_q;
    assign word[k]  = word_q;
    assign opb[k]   = opb_q;

    if (k == STAGES - 1) begin : g_last
      logic ovf_d;
      // Carry into the MSB is recovered from the MSB sum bit and its operand bits
      assign ovf_d = (ain[WIDTH-1] ^ bin[WIDTH-1] ^ slice[CHUNK-1]) ^ slice[CHUNK];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv[k]) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = valid[STAGES-1];
  assign sum       = word[STAGES-1];
  assign cout      = carry[STAGES-1];
  assign ovf       = ovf_q;

endmodule
